// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the two-master data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic mid_t;

    localparam int MEM_AW_DEF = 7;
    localparam int ADDR_W_MAX = 64;

    // Misaligned word access, or any address bit at/above the memory size.
    function automatic logic addr_err(input logic [ADDR_W_MAX-1:0] addr, input int mem_aw);
        return (addr[1:0] != 2'b00) || ((addr >> mem_aw) != '0);
    endfunction

endpackage

// File: rtl/dm_rr_picker.sv
// Two-way combinational picker: a lone requester wins; on contention, round-robin
// mode picks the master that did not win last, fixed mode picks master 0.
module dm_rr_picker
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mid_t       last_winner,
    input  logic       rr_mode,
    output mid_t       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11 && rr_mode)
            winner = ~last_winner;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter/sequencer for the byte-addressed data memory.
// Define DM_ARB_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

`ifdef DM_ARB_RR_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    state_t            state, state_nxt;
    mid_t              last_winner, winner, cap_id;
    logic              pick_vld, grant, in_err;
    logic              cap_we, cap_err;
    logic [ADDR_W-1:0] cap_addr, req_addr;
    logic [DATA_W-1:0] cap_wdata, rdata_q;

    dm_rr_picker u_pick (
        .req         ({m1_req, m0_req}),
        .last_winner (last_winner),
        .rr_mode     (RR_MODE),
        .winner      (winner),
        .valid       (pick_vld)
    );

    // rst_n gating keeps gnt low while reset is held even though IDLE is reached.
    assign grant    = (state == IDLE) && pick_vld && rst_n;
    assign req_addr = winner ? m1_addr : m0_addr;
    assign in_err   = addr_err(ADDR_W_MAX'(req_addr), MEM_AW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = in_err ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
            cap_id      <= 1'b0;
            cap_we      <= 1'b0;
            cap_err     <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rdata_q     <= '0;
        end else begin
            if (grant) begin
                last_winner <= winner;
                cap_id      <= winner;
                cap_we      <= winner ? m1_we : m0_we;
                cap_addr    <= req_addr;
                cap_wdata   <= winner ? m1_wdata : m0_wdata;
                cap_err     <= in_err;
                rdata_q     <= '0;
            end
            if (state == ACCESS)
                rdata_q <= cap_we ? '0 : mem_read_data;
        end
    end

    always_comb begin
        m0_gnt           = grant && !winner;
        m1_gnt           = grant && winner;
        m0_rvalid        = 1'b0;
        m0_rdata         = '0;
        m0_err           = 1'b0;
        m1_rvalid        = 1'b0;
        m1_rdata         = '0;
        m1_err           = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (state == ACCESS) begin
            mem_address      = cap_addr;
            mem_write_data   = cap_wdata;
            mem_write_enable = cap_we;
            mem_read_enable  = !cap_we;
        end
        if (state == RESP) begin
            if (!cap_id) begin
                m0_rvalid = 1'b1;
                m0_rdata  = rdata_q;
                m0_err    = cap_err;
            end else begin
                m1_rvalid = 1'b1;
                m1_rdata  = rdata_q;
                m1_err    = cap_err;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a 128-byte behavioural memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;

    logic [31:0] mem [0:31];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address[6:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[6:2]] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    // One transaction: lat counts cycles from gnt to rvalid; *1 values sampled at gnt+1.
    task automatic txn(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic wen1, output logic ren1, output logic [31:0] addr1,
                       output logic saw_en);
        logic got;
        got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        wen1 = 1'b0; ren1 = 1'b0; addr1 = '0; saw_en = 1'b0;
        @(posedge clk); #1;
        drive(m, 1'b1, we, a, d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_gnt : m1_gnt;
        end
        check("gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, '0, '0);
        if (!got) return;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin wen1 = mem_write_enable; ren1 = mem_read_enable; addr1 = mem_address; end
            if (mem_write_enable || mem_read_enable) saw_en = 1'b1;
            if (lat < 0 && ((m == 0) ? m0_rvalid : m1_rvalid)) begin
                lat = i;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                er  = (m == 0) ? m0_err : m1_err;
            end
        end
    endtask

    logic [31:0] rd, a1;
    logic        er, w1, r1, se, rv_seen;
    int          lat;
    int          gid[$], gcy[$];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // reset state, with a request pending that must not be granted
        m0_req = 1'b1;
        #2;
        check("rst_gnt", 32'(m0_gnt), 32'd0);
        check("rst_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
        check("rst_en", 32'(mem_write_enable | mem_read_enable), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        m0_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: m0 write then read addr 4
        txn(0, 1'b1, 32'd4, 32'hDEADBEEF, rd, er, lat, w1, r1, a1, se);
        check("t1_wr_we1", 32'(w1), 32'd1);
        check("t1_wr_addr1", a1, 32'd4);
        check("t1_wr_lat", lat, 32'd2);
        check("t1_wr_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'd4, '0, rd, er, lat, w1, r1, a1, se);
        check("t1_rd_re1", 32'(r1), 32'd1);
        check("t1_rd_lat", lat, 32'd2);
        check("t1_rd_rdata", rd, 32'hDEADBEEF);
        check("t1_rd_err", 32'(er), 32'd0);

        // 3: m1 misaligned read
        txn(1, 1'b0, 32'd6, '0, rd, er, lat, w1, r1, a1, se);
        check("t3_lat", lat, 32'd1);
        check("t3_err", 32'(er), 32'd1);
        check("t3_rdata", rd, 32'd0);
        check("t3_no_mem_en", 32'(se), 32'd0);

        // 4: out-of-range write leaves memory untouched
        txn(0, 1'b1, 32'd0, 32'h0BADF00D, rd, er, lat, w1, r1, a1, se);
        txn(0, 1'b1, 32'h80, 32'hFFFFFFFF, rd, er, lat, w1, r1, a1, se);
        check("t4_err", 32'(er), 32'd1);
        check("t4_lat", lat, 32'd1);
        check("t4_no_mem_en", 32'(se), 32'd0);
        txn(0, 1'b0, 32'd0, '0, rd, er, lat, w1, r1, a1, se);
        check("t4_addr0", rd, 32'h0BADF00D);

        // 6: top word of memory via m1
        txn(1, 1'b1, 32'd124, 32'hA5A5A5A5, rd, er, lat, w1, r1, a1, se);
        check("t6_wr_err", 32'(er), 32'd0);
        txn(1, 1'b0, 32'd124, '0, rd, er, lat, w1, r1, a1, se);
        check("t6_rdata", rd, 32'hA5A5A5A5);
        check("t6_err", 32'(er), 32'd0);
        txn(1, 1'b0, 32'd0, '0, rd, er, lat, w1, r1, a1, se);
        check("t6_addr0", rd, 32'h0BADF00D);

        // 2: both masters hold read requests; last winner so far is m1
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd4, '0);
        drive(1, 1'b1, 1'b0, 32'd124, '0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m0_gnt) begin gid.push_back(0); gcy.push_back(c); end
            if (m1_gnt) begin gid.push_back(1); gcy.push_back(c); end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("t2_gnt_count", gid.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gid.size()) begin
`ifdef DM_ARB_RR_EN
                check($sformatf("t2_id%0d", k), gid[k], k % 2);
`else
                check($sformatf("t2_id%0d", k), gid[k], 32'd0);
`endif
                check($sformatf("t2_cyc%0d", k), gcy[k], 3 * k);
            end
        end
        repeat (3) @(posedge clk);

        // 5: reset during ACCESS of a write
        txn(0, 1'b1, 32'd12, 32'h00000055, rd, er, lat, w1, r1, a1, se);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'd12, 32'h11223344);
        @(negedge clk);
        check("t5_gnt", 32'(m0_gnt), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        check("t5_access_we", 32'(mem_write_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(mem_write_enable), 32'd0);
        rv_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid || mem_write_enable) rv_seen = 1'b1;
        end
        check("t5_no_rvalid", 32'(rv_seen), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd12, '0);
        drive(1, 1'b1, 1'b0, 32'd0, '0);
        @(negedge clk);
        check("t5_first_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("t5_rvalid", 32'(m0_rvalid), 32'd1);
        check("t5_kept", m0_rdata, 32'h00000055);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
